instr_fetch_decode: RTL and testbench

Upstream neighbour of the register-file read stage in the multi-cycle MIPS datapath. It holds the PC and a word-addressed instruction memory, and fetches one instruction at a time. It splits each instruction into opcode/rs/rt/rd/imm fields and decodes the RegRead/RegWrite/RegDst controls consumed by the register file. It also resolves BEQ by waiting on a compare result from downstream before updating the PC.

---
 rtl/instr_fetch_decode_if.sv | 30 +++
 rtl/instr_fetch_decode.sv | 75 +++++++
 tb/tb_instr_fetch_decode.sv | 118 +++++++++++
 3 files changed

// File: rtl/instr_fetch_decode_if.sv
// instr_fetch_decode_if: program-load, branch-resolve and decoded-field bus of the fetch/decode stage.
interface instr_fetch_decode_if #(parameter int ADDR_W = 8);
  logic              stall;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              branch_valid;
  logic              branch_eq;
  logic [31:0]       pc;
  logic [31:0]       instr;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic              RegRead;
  logic              RegWrite;
  logic              RegDst;
  logic              instr_valid;
  logic              illegal;
  logic              halted;
  modport master (
    output stall, imem_we, imem_addr, imem_wdata, branch_valid, branch_eq,
    input  pc, instr, opcode, rs, rt, rd, imm, RegRead, RegWrite, RegDst, instr_valid, illegal, halted
  );
  modport slave (
    input  stall, imem_we, imem_addr, imem_wdata, branch_valid, branch_eq,
    output pc, instr, opcode, rs, rt, rd, imm, RegRead, RegWrite, RegDst, instr_valid, illegal, halted
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: PC + word-addressed imem, multi-cycle fetch/decode FSM with BEQ resolution.
module instr_fetch_decode #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  reset,
  instr_fetch_decode_if.slave  bus
);
  localparam int ADDR_W = $clog2(IMEM_DEPTH);
  typedef enum logic [1:0] {FETCH, DECODE, BRANCH, HALT} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, fetch_w, br_off;
  logic [31:0] mem [IMEM_DEPTH];
  logic [3:0]  ctl_q, ctl_d;
  logic [5:0]  op_f;
  logic        rtype, ldx, stx, sent;
  always_ff @(posedge clk)
    if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;
  assign fetch_w = mem[pc_q[ADDR_W+1:2]];
  assign br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  // Controls are decoded from the word as it is fetched so they land together with instr
  always_comb begin
    op_f  = fetch_w[31:26];
    rtype = op_f == 6'h00;
    ldx   = op_f inside {6'h08, 6'h23, 6'h24, 6'h25, 6'h30};
    stx   = op_f inside {6'h2B, 6'h04};
    sent  = &fetch_w;
    ctl_d = {~(rtype | ldx | stx | sent), rtype | ldx | stx, rtype | ldx, rtype};
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        state_d = &instr_q ? HALT : instr_q[31:26] == 6'h04 ? BRANCH : FETCH;
        pc_d    = state_d == FETCH ? pc_q + 32'd4 : pc_q;
      end
      BRANCH: begin
        state_d = bus.branch_valid ? FETCH : BRANCH;
        pc_d    = bus.branch_valid ? pc_q + 32'd4 + (bus.branch_eq ? br_off : 32'd0) : pc_q;
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ctl_q   <= '0;
    end else if (!bus.stall) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == FETCH) begin
        instr_q <= fetch_w;
        ctl_q   <= ctl_d;
      end
    end
  end
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.rs          = instr_q[25:21];
  assign bus.rt          = instr_q[20:16];
  assign bus.rd          = instr_q[15:11];
  assign bus.imm         = instr_q[15:0];
  assign bus.illegal     = ctl_q[3];
  assign bus.RegRead     = ctl_q[2];
  assign bus.RegWrite    = ctl_q[1];
  assign bus.RegDst      = ctl_q[0];
  assign bus.instr_valid = state_q == DECODE && !bus.stall;
  assign bus.halted      = state_q == HALT;
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed vectors on two instances (RESET_PC 0 and 32'hFFFF_FFFC).
module tb_instr_fetch_decode;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  instr_fetch_decode_if #(.ADDR_W(8)) bus0 ();
  instr_fetch_decode_if #(.ADDR_W(8)) bus1 ();
  instr_fetch_decode #(.IMEM_DEPTH(256), .RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  instr_fetch_decode #(.IMEM_DEPTH(256), .RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic ld0(input logic [7:0] a, input logic [31:0] d);
    bus0.imem_we = 1'b1; bus0.imem_addr = a; bus0.imem_wdata = d;
  endtask
  task automatic ld1(input logic [7:0] a, input logic [31:0] d);
    bus1.imem_we = 1'b1; bus1.imem_addr = a; bus1.imem_wdata = d;
  endtask
  initial begin
    bus0.stall = 0; bus0.imem_we = 0; bus0.imem_addr = 0; bus0.imem_wdata = 0;
    bus0.branch_valid = 0; bus0.branch_eq = 0;
    bus1.stall = 0; bus1.imem_we = 0; bus1.imem_addr = 0; bus1.imem_wdata = 0;
    bus1.branch_valid = 0; bus1.branch_eq = 0;
    tick();
    ld0(8'd0, 32'h012A_4020); ld1(8'd255, 32'hF800_0000); tick();
    ld0(8'd1, 32'h8D28_0004); ld1(8'd0, 32'h8D28_0004); tick();
    ld0(8'd2, 32'h1000_FFFE); bus1.imem_we = 0; tick();
    ld0(8'd3, 32'hFFFF_FFFF); tick();
    bus0.imem_we = 0; tick();
    chk("rst_pc", bus0.pc, 32'h0);
    chk("rst_instr", bus0.instr, 32'h0);
    chk("rst_ctl", {bus0.instr_valid, bus0.illegal, bus0.halted, bus0.RegRead, bus0.RegWrite, bus0.RegDst}, 0);
    chk("rst_pc1", bus1.pc, 32'hFFFF_FFFC);
    reset = 0;
    tick();
    chk("r_valid", bus0.instr_valid, 1);
    chk("r_fields", {bus0.opcode, bus0.rs, bus0.rt, bus0.rd}, {6'h00, 5'd9, 5'd10, 5'd8});
    chk("r_ctl", {bus0.illegal, bus0.RegRead, bus0.RegWrite, bus0.RegDst}, 4'b0111);
    chk("r_pc", bus0.pc, 32'h0);
    chk("w_ill_valid", bus1.instr_valid, 1);
    chk("w_ill_op", bus1.opcode, 6'h3E);
    chk("w_ill_ctl", {bus1.illegal, bus1.RegRead, bus1.RegWrite, bus1.RegDst}, 4'b1000);
    chk("w_ill_pc", bus1.pc, 32'hFFFF_FFFC);
    bus0.stall = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", bus0.instr_valid, 0);
      chk("stall_pc", bus0.pc, 32'h0);
      chk("stall_rd", bus0.rd, 5'd8);
      if (i == 0) chk("w_pc", bus1.pc, 32'h0);
      if (i == 1) chk("w_fetch0", {bus1.instr_valid, bus1.instr}, {1'b1, 32'h8D28_0004});
    end
    bus0.stall = 0;
    #1 chk("stall_rel_valid", bus0.instr_valid, 1);
    tick();
    chk("r_next_pc", bus0.pc, 32'h4);
    chk("r_next_valid", bus0.instr_valid, 0);
    tick();
    chk("lw_valid", bus0.instr_valid, 1);
    chk("lw_fields", {bus0.opcode, bus0.rt, bus0.imm}, {6'h23, 5'd8, 16'h0004});
    chk("lw_ctl", {bus0.illegal, bus0.RegRead, bus0.RegWrite, bus0.RegDst}, 4'b0110);
    tick();
    chk("lw_next_pc", bus0.pc, 32'h8);
    bus0.branch_valid = 1; bus0.branch_eq = 1;
    tick();
    bus0.branch_valid = 0; bus0.branch_eq = 0;
    chk("beq_valid", bus0.instr_valid, 1);
    chk("beq_fields", {bus0.opcode, bus0.imm}, {6'h04, 16'hFFFE});
    chk("beq_ctl", {bus0.illegal, bus0.RegRead, bus0.RegWrite, bus0.RegDst}, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("beq_wait_pc", bus0.pc, 32'h8);
      chk("beq_wait_valid", bus0.instr_valid, 0);
    end
    bus0.branch_valid = 1; bus0.branch_eq = 1;
    tick();
    bus0.branch_valid = 0;
    chk("beq_taken_pc", bus0.pc, 32'h4);
    tick();
    chk("beq_refetch", {bus0.instr_valid, bus0.opcode}, {1'b1, 6'h23});
    tick();
    tick();
    chk("beq2_op", {bus0.instr_valid, bus0.opcode}, {1'b1, 6'h04});
    tick();
    bus0.branch_valid = 1; bus0.branch_eq = 0;
    tick();
    bus0.branch_valid = 0;
    chk("beq_nt_pc", bus0.pc, 32'hC);
    ld0(8'd3, 32'h012A_4020);
    tick();
    bus0.imem_we = 0;
    chk("wr_same_old", bus0.instr, 32'hFFFF_FFFF);
    chk("halt_dec", {bus0.instr_valid, bus0.illegal, bus0.RegRead, bus0.RegWrite, bus0.RegDst}, 5'b10000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_h", bus0.halted, 1);
      chk("halt_pc", bus0.pc, 32'hC);
    end
    reset = 1;
    tick();
    reset = 0;
    chk("rst2_pc", bus0.pc, 32'h0);
    chk("rst2_halt", {bus0.halted, bus0.instr_valid, bus0.RegRead}, 0);
    tick();
    chk("rst2_fetch", {bus0.instr_valid, bus0.instr}, {1'b1, 32'h012A_4020});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
